txt_vram_arbiter: RTL and testbench
===================================

# txt_vram_arbiter

Single-port display (character) memory arbiter for the text-mode GPU path. Shares one synchronous-read RAM of 40x30 ASCII cells between the text renderer's character fetches, CPU character writes and a hardware clear-screen sweep. Renderer fetches have absolute priority so scan-out timing is never disturbed. CPU writes are buffered in a small FIFO and drained in idle slots.

## Interface
- ADDR_W, 12, cell address width
- DATA_W, 8, character code width
- FIFO_DEPTH, 4, CPU write buffer entries (power of two)
- CELLS, 1200, valid cells (40 columns x 30 rows); legal addresses 0..CELLS-1

Ports: reset clr, asynchronous, active-low; clock clk.

- clk  in  1  clock
- clr  in  1  asynchronous active-low reset
- rd_req  in  1  renderer fetch request, single-cycle pulse
- rd_addr  in  ADDR_W  renderer cell address
- rd_data  out  DATA_W  fetched character (passthrough of mem_rdata)
- rd_valid  out  1  rd_data valid this cycle
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  FIFO can accept
- cpu_wr_addr  in  ADDR_W  CPU cell address
- cpu_wr_data  in  DATA_W  CPU character
- addr_err  out  1  one-cycle pulse: CPU write with address >= CELLS discarded
- clr_start  in  1  start clear-screen sweep
- clr_char  in  DATA_W  fill character, sampled with clr_start
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse at sweep completion
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- One RAM slot decided per cycle, priority: renderer read > clear write > FIFO write.
- States: IDLE, CLEAR. IDLE->CLEAR on clr_start (clr_char and cell counter=0 latched). CLEAR->IDLE after counter CELLS-1 is issued. clr_start in CLEAR ignored.
- CLEAR: each non-read slot writes clr_char to counter address, counter +1. FIFO is not drained in CLEAR; pushes still accepted, so CPU writes queued during a sweep land after it.
- FIFO: push when cpu_wr_valid && cpu_wr_ready; cpu_wr_ready = (count != FIFO_DEPTH). Full: ready low, no push. Push and pop same cycle: count unchanged, order preserved.
- Address check at push: cpu_wr_addr >= CELLS -> handshake completes, entry not stored, addr_err=1 next cycle.
- Renderer addresses are not checked; passed through unchanged.
- Counter and addresses are ADDR_W unsigned; no wrap past CELLS-1.

## Timing
- All outputs registered except rd_data (= mem_rdata) and cpu_wr_ready (from count).
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, addr_err=0, clr_busy=0, clr_done=0, cpu_wr_ready=1; FIFO empty, state IDLE.
- Read: rd_req at cycle N -> mem_en=1, mem_we=0, mem_addr=rd_addr at N+1 -> rd_valid=1 at N+2. Back-to-back rd_req every cycle supported.
- Write: slot decided at N -> mem_en=1, mem_we=1 at N+1. Push to empty FIFO at N -> earliest RAM write at N+2.
- Idle slot: mem_en=0, mem_we=0.
- clr_start at N -> clr_busy=1 at N+1; with no reads, last fill write on RAM at N+CELLS+1, same cycle clr_done=1 and clr_busy=0. Each rd_req during sweep delays completion by one cycle.
- clr_start and cpu push same cycle: both accepted.
- Reset mid-sweep or with FIFO non-empty: sweep aborted, no clr_done, FIFO contents lost.

## Test plan
- Read latency: rd_req with rd_addr=41, mem model returns 0x41 -> mem_addr=41 at N+1, rd_valid=1 and rd_data=0x41 at N+2.
- CPU burst: 6 writes (addr 0..5, data 0x30..0x35) with rd_req every cycle -> ready drops after 4 accepted, no RAM write until rd_req stops, then all 6 written in order.
- Contention: rd_req every 8th cycle (pixel-slot pattern) while FIFO non-empty -> read slots never delayed; writes fill remaining slots.
- Clear: clr_start, clr_char=0x20, no reads -> 1200 writes to 0..1199 of 0x20, clr_done pulse at N+1201, clr_busy high N+1..N+1200.
- Ordering: CPU write addr 5 data 0x41 pushed mid-sweep -> cell 5 reads 0x41 after clr_done; addr 1200 write -> addr_err pulse, RAM untouched.
- Reset at sweep cell 600 with 2 FIFO entries -> all outputs to reset values, no clr_done, no further RAM writes.

Source files
------------

// File: rtl/txt_vram_arbiter.sv
// txt_vram_arbiter: one-port text VRAM arbiter (renderer read > clear sweep > FIFO-buffered CPU write); clk/clr(async low), rd_*, cpu_wr_*, clr_*, mem_*
module txt_vram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CELLS = 1200
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              addr_err,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_char,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(CELLS - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, nstate;
  logic [ADDR_W-1:0] cnt, n_cnt, n_addr;
  logic [DATA_W-1:0] fill, n_wdata;
  logic [ADDR_W-1:0] fa [FIFO_DEPTH];
  logic [DATA_W-1:0] fd [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic hs, bad, push, pop, clear_slot, start, n_en, n_we, n_done;
  assign rd_data = mem_rdata;
  assign clr_busy = state == CLEAR;
  assign cpu_wr_ready = count != CW'(FIFO_DEPTH);
  assign hs = cpu_wr_valid && cpu_wr_ready;
  assign bad = hs && cpu_wr_addr >= CELLS_A;
  assign push = hs && !bad;
  assign start = state == IDLE && clr_start;
  assign clear_slot = !rd_req && state == CLEAR;
  assign pop = !rd_req && state == IDLE && count != '0;
  always_comb begin
    nstate = state;
    n_cnt = start ? '0 : clear_slot ? cnt + 1'b1 : cnt;
    n_en = rd_req || clear_slot || pop;
    n_we = !rd_req && (clear_slot || pop);
    n_addr = rd_req ? rd_addr : clear_slot ? cnt : fa[rp];
    n_wdata = clear_slot ? fill : fd[rp];
    n_done = clear_slot && cnt == LAST_A;
    if (start) nstate = CLEAR;
    if (n_done) nstate = IDLE;
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state <= IDLE;
      cnt <= '0;
      fill <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= n_cnt;
      fill <= start ? clr_char : fill;
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
      mem_en <= n_en;
      mem_we <= n_we;
      mem_addr <= n_addr;
      mem_wdata <= n_wdata;
      rd_valid <= mem_en && !mem_we;
      addr_err <= bad;
      clr_done <= n_done;
    end
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= cpu_wr_addr;
      fd[wp] <= cpu_wr_data;
    end
endmodule

// File: tb/tb_txt_vram_arbiter.sv
// tb_txt_vram_arbiter: table vectors plus burst, contention, sweep and reset sequences against a RAM model
module tb_txt_vram_arbiter;
  logic clk = 1'b0, clr = 1'b0;
  logic rd_req = 1'b0, rd_valid, cpu_wr_valid = 1'b0, cpu_wr_ready, addr_err;
  logic clr_start = 1'b0, clr_busy, clr_done, mem_en, mem_we;
  logic [11:0] rd_addr = '0, cpu_wr_addr = '0, mem_addr;
  logic [7:0] rd_data, cpu_wr_data = '0, clr_char = '0, mem_wdata, mem_rdata = '0;
  logic [7:0] mem [4096];
  int la[$], ld[$];
  int total = 0, pass = 0;
  typedef struct {
    int rd, ra, wv, wa, wd;
    int en, we, ad, wdat, rv, rdat, err, rdy;
  } vec_t;
  vec_t v[11];
  txt_vram_arbiter dut (
    .clk(clk), .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .addr_err(addr_err),
    .clr_start(clr_start), .clr_char(clr_char), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  always @(posedge clk)
    if (mem_en && mem_we) begin
      la.push_back(int'(mem_addr));
      ld.push_back(int'(mem_wdata));
    end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic run_sweep(input int with_rd, output int done_at);
    int k;
    clr_char = 8'h20;
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    chk("clr_busy_start", int'(clr_busy), 1);
    k = 1;
    done_at = 0;
    while (done_at == 0 && k < 1400) begin
      cpu_wr_valid = with_rd == 0 && k == 10;
      cpu_wr_addr = 12'd5;
      cpu_wr_data = 8'h41;
      clr_start = k == 20;
      clr_char = (k == 20) ? 8'h77 : 8'h20;
      rd_req = with_rd != 0 && (k == 100 || k == 200 || k == 300);
      rd_addr = 12'd7;
      cyc();
      k++;
      if (clr_done) done_at = k;
      else if (!clr_busy) chk("clr_busy_during", 0, 1);
    end
    cpu_wr_valid = 1'b0;
    clr_start = 1'b0;
    rd_req = 1'b0;
    chk("clr_busy_at_done", int'(clr_busy), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end
  initial begin
    int wi, hs, pushed, d, nbad, n, seen_done, seen_en;
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    mem[41] = 8'h41;
    v[0]  = '{1, 41, 0, 0, 0,       1, 0, 41, 0, 0, 0, 0, 1};
    v[1]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 'h41, 0, 1};
    v[2]  = '{0, 0, 1, 7, 'h55,     0, 0, 0, 0, 0, 0, 0, 1};
    v[3]  = '{0, 0, 0, 0, 0,        1, 1, 7, 'h55, 0, 0, 0, 1};
    v[4]  = '{0, 0, 1, 1200, 'h99,  0, 0, 0, 0, 0, 0, 1, 1};
    v[5]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1};
    v[6]  = '{1, 7, 1, 8, 'h66,     1, 0, 7, 0, 0, 0, 0, 1};
    v[7]  = '{0, 0, 0, 0, 0,        1, 1, 8, 'h66, 1, 'h55, 0, 1};
    v[8]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1};
    v[9]  = '{1, 1200, 0, 0, 0,     1, 0, 1200, 0, 0, 0, 0, 1};
    v[10] = '{0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 'hEE, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_addr_err", int'(addr_err), 0);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_clr_done", int'(clr_done), 0);
    chk("rst_ready", int'(cpu_wr_ready), 1);
    @(negedge clk);
    clr = 1'b1;
    cyc();
    for (int i = 0; i < 11; i++) begin
      rd_req = v[i].rd != 0;
      rd_addr = 12'(v[i].ra);
      cpu_wr_valid = v[i].wv != 0;
      cpu_wr_addr = 12'(v[i].wa);
      cpu_wr_data = 8'(v[i].wd);
      cyc();
      chk($sformatf("v%0d_en", i), int'(mem_en), v[i].en);
      if (v[i].en != 0) chk($sformatf("v%0d_we", i), int'(mem_we), v[i].we);
      if (v[i].en != 0) chk($sformatf("v%0d_addr", i), int'(mem_addr), v[i].ad);
      if (v[i].en != 0 && v[i].we != 0) chk($sformatf("v%0d_wdata", i), int'(mem_wdata), v[i].wdat);
      chk($sformatf("v%0d_rd_valid", i), int'(rd_valid), v[i].rv);
      if (v[i].rv != 0) chk($sformatf("v%0d_rd_data", i), int'(rd_data), v[i].rdat);
      chk($sformatf("v%0d_addr_err", i), int'(addr_err), v[i].err);
      chk($sformatf("v%0d_ready", i), int'(cpu_wr_ready), v[i].rdy);
    end
    rd_req = 1'b0;
    cpu_wr_valid = 1'b0;
    la.delete();
    ld.delete();
    wi = 0;
    rd_req = 1'b1;
    rd_addr = 12'd100;
    for (int c = 0; c < 22; c++) begin
      if (c == 10) begin
        chk("burst_accepted", wi, 4);
        chk("burst_ready_low", int'(cpu_wr_ready), 0);
        chk("burst_no_write", la.size(), 0);
        rd_req = 1'b0;
      end
      cpu_wr_valid = wi < 6;
      cpu_wr_addr = 12'(wi);
      cpu_wr_data = 8'(8'h30 + wi);
      @(negedge clk);
      hs = int'(cpu_wr_valid && cpu_wr_ready);
      cyc();
      if (hs != 0) wi++;
    end
    cpu_wr_valid = 1'b0;
    repeat (4) cyc();
    chk("burst_count", la.size(), 6);
    for (int i = 0; i < 6 && i < la.size(); i++) begin
      chk($sformatf("burst_addr%0d", i), la[i], i);
      chk($sformatf("burst_data%0d", i), ld[i], 'h30 + i);
    end
    la.delete();
    ld.delete();
    pushed = 0;
    for (int c = 0; c < 40; c++) begin
      rd_req = c % 8 == 0;
      rd_addr = 12'(300 + c);
      cpu_wr_valid = pushed < 8;
      cpu_wr_addr = 12'(200 + pushed);
      cpu_wr_data = 8'(pushed);
      @(negedge clk);
      hs = int'(cpu_wr_valid && cpu_wr_ready);
      cyc();
      if (hs != 0) pushed++;
      if (rd_req) begin
        chk("cont_rd_slot", int'(mem_en && !mem_we), 1);
        chk("cont_rd_addr", int'(mem_addr), 300 + c);
      end
    end
    rd_req = 1'b0;
    cpu_wr_valid = 1'b0;
    repeat (4) cyc();
    chk("cont_writes", la.size(), 8);
    nbad = 0;
    for (int i = 0; i < la.size(); i++) if (la[i] != 200 + i || ld[i] != i) nbad++;
    chk("cont_order_bad", nbad, 0);
    la.delete();
    ld.delete();
    run_sweep(0, d);
    chk("clr_done_at", d, 1201);
    cyc();
    chk("clr_done_pulse", int'(clr_done), 0);
    repeat (4) cyc();
    chk("clr_write_count", la.size(), 1201);
    nbad = 0;
    for (int i = 0; i < 1200 && i < la.size(); i++) if (la[i] != i || ld[i] != 'h20) nbad++;
    chk("clr_fill_bad", nbad, 0);
    if (la.size() > 1200) begin
      chk("order_addr", la[1200], 5);
      chk("order_data", ld[1200], 'h41);
    end
    rd_req = 1'b1;
    rd_addr = 12'd5;
    cyc();
    rd_req = 1'b0;
    cyc();
    chk("order_rv", int'(rd_valid), 1);
    chk("order_cell5", int'(rd_data), 'h41);
    run_sweep(1, d);
    chk("clr_rd_delay_done_at", d, 1204);
    la.delete();
    ld.delete();
    clr_char = 8'h2A;
    clr_start = 1'b1;
    cpu_wr_valid = 1'b1;
    cpu_wr_addr = 12'd900;
    cpu_wr_data = 8'h01;
    cyc();
    clr_start = 1'b0;
    cpu_wr_addr = 12'd901;
    cpu_wr_data = 8'h02;
    cyc();
    cpu_wr_valid = 1'b0;
    n = 0;
    while (!(mem_en && mem_we && mem_addr == 12'd600) && n < 1000) begin
      cyc();
      n++;
    end
    chk("rst_reached_600", int'(mem_addr), 600);
    #2 clr = 1'b0;
    #1;
    chk("mrst_mem_en", int'(mem_en), 0);
    chk("mrst_mem_we", int'(mem_we), 0);
    chk("mrst_mem_addr", int'(mem_addr), 0);
    chk("mrst_clr_busy", int'(clr_busy), 0);
    chk("mrst_clr_done", int'(clr_done), 0);
    chk("mrst_ready", int'(cpu_wr_ready), 1);
    @(negedge clk);
    clr = 1'b1;
    n = la.size();
    seen_done = 0;
    seen_en = 0;
    repeat (30) begin
      cyc();
      if (clr_done) seen_done = 1;
      if (mem_en) seen_en = 1;
    end
    chk("mrst_no_writes", la.size(), n);
    chk("mrst_no_done", seen_done, 0);
    chk("mrst_no_en", seen_en, 0);
    chk("mrst_busy_after", int'(clr_busy), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
